// File: rtl/fsqrt_arbiter.sv
// fsqrt_arbiter: shares one free-running pipelined fsqrt unit between two
// requesters. Issue is round-robin and credit-limited, so that every result
// that leaves the pipeline always has a free slot in its owner's response FIFO.
module fsqrt_arbiter #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    output logic [31:0] sq_x,
    input  logic [31:0] sq_y,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   OUT_LIMIT = DEPTH[CW:0];
    localparam logic [CW-1:0] FIFO_FULL = DEPTH[CW-1:0];

    logic [1:0]    req_valid;
    logic [1:0]    rsp_ready;
    logic [31:0]   req_x [2];
    logic [1:0]    eligible;
    logic [1:0]    cand;
    logic [1:0]    grant;
    logic [1:0]    retire;
    logic [1:0]    fifo_rd;
    logic [1:0]    fifo_ne;
    logic [CW:0]   out_cnt [2];
    logic [CW-1:0] inflight [2];
    logic [CW-1:0] fifo_cnt [2];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [31:0]   fifo_mem [2][DEPTH];
    logic [LAT:0]  tag_vld;
    logic [LAT:0]  tag_own;
    logic          rr_ptr;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_x[0]  = req0_x;
    assign req_x[1]  = req1_x;

    // Stage LAT of the tag pipe lines up with sq_y: its owner takes the result.
    assign retire  = {tag_vld[LAT] & tag_own[LAT], tag_vld[LAT] & ~tag_own[LAT]};
    assign fifo_rd = fifo_ne & rsp_ready;

    // Credit check and round-robin pick; nothing is granted while in reset.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            out_cnt[n]  = {1'b0, inflight[n]} + {1'b0, fifo_cnt[n]};
            eligible[n] = out_cnt[n] < OUT_LIMIT;
            fifo_ne[n]  = fifo_cnt[n] != '0;
        end
        cand  = req_valid & eligible & {2{~rst}};
        grant = cand;
        if (cand == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
    end

    // Operand register, ownership tag pipe and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_x    <= '0;
            tag_vld <= '0;
            tag_own <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            tag_vld <= {tag_vld[LAT-1:0], |grant};
            tag_own <= {tag_own[LAT-1:0], grant[1]};
            sq_x    <= grant[1] ? req_x[1] : (grant[0] ? req_x[0] : 32'h0);
            if (grant[0]) begin
                rr_ptr <= 1'b1;
            end else if (grant[1]) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // Per-requester credit counters and FIFO pointers, updated by net delta.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                inflight[n] <= '0;
                fifo_cnt[n] <= '0;
                wr_ptr[n]   <= '0;
                rd_ptr[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                case ({grant[n], retire[n]})
                    2'b10:   inflight[n] <= inflight[n] + CW'(1);
                    2'b01:   inflight[n] <= inflight[n] - CW'(1);
                    default: ;
                endcase
                case ({retire[n], fifo_rd[n]})
                    2'b10:   fifo_cnt[n] <= fifo_cnt[n] + CW'(1);
                    2'b01:   fifo_cnt[n] <= fifo_cnt[n] - CW'(1);
                    default: ;
                endcase
                if (retire[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + AW'(1);
                end
                if (fifo_rd[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + AW'(1);
                end
            end
        end
    end

    // Response storage; no reset needed since the counts gate visibility.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (retire[n]) begin
                fifo_mem[n][wr_ptr[n]] <= sq_y;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(retire[0] && fifo_cnt[0] == FIFO_FULL))
        else $error("fsqrt_arbiter: response FIFO 0 written while full");
    assert property (@(posedge clk) disable iff (rst) !(retire[1] && fifo_cnt[1] == FIFO_FULL))
        else $error("fsqrt_arbiter: response FIFO 1 written while full");

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = fifo_ne[0];
    assign rsp1_valid = fifo_ne[1];
    assign rsp0_y     = fifo_mem[0][rd_ptr[0]];
    assign rsp1_y     = fifo_mem[1][rd_ptr[1]];

endmodule
